// File: rtl/ask_sym_src.sv
// 4-ASK test-stimulus source: PRBS-driven Gray-mapped symbols, upsampled to sample rate,
// with zero-stuff, hold, periodic-impulse and silence modes.
module ask_sym_src #(
  parameter int unsigned              WIDTH      = 18,
  parameter logic [21:0]              SEED       = 22'h3FFFFF,
  parameter logic signed [WIDTH-1:0]  MAG_HI     = 18'sd98303,
  parameter logic signed [WIDTH-1:0]  MAG_LO     = 18'sd32768,
  parameter logic signed [WIDTH-1:0]  IMP_AMP    = 18'sd98303,
  parameter int unsigned              IMP_PERIOD = 64
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     sam_clk_en,
  input  logic                     sym_clk_en,
  input  logic [1:0]               mode,
  output logic signed [WIDTH-1:0]  x_out,
  output logic [1:0]               sym_out,
  output logic                     sym_valid
);

  localparam int unsigned    CW   = (IMP_PERIOD > 2) ? $clog2(IMP_PERIOD) : 1;
  localparam logic [CW-1:0]  LAST = CW'(IMP_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t                   r_state;
  logic [21:0]              r_lfsr;
  logic [1:0]               r_mode;
  logic [CW-1:0]            r_imp_cnt;
  logic signed [WIDTH-1:0]  r_x;
  logic [1:0]               r_sym;
  logic                     r_valid;

  logic                     w_sym_tick;
  logic                     w_fb1;
  logic                     w_fb2;
  logic [1:0]               w_mode_eff;
  logic signed [WIDTH-1:0]  w_level;

  assign w_sym_tick = sam_clk_en & sym_clk_en;
  // Two Fibonacci steps folded into one: second feedback taps are the first taps shifted by one.
  assign w_fb1      = r_lfsr[21] ^ r_lfsr[20];
  assign w_fb2      = r_lfsr[20] ^ r_lfsr[19];
  // The mode being latched on this tick already governs this tick's sample.
  assign w_mode_eff = w_sym_tick ? mode : r_mode;

  always_comb begin
    w_level = '0;
    unique case ({w_fb1, w_fb2})
      2'b00: w_level = -MAG_HI;
      2'b01: w_level = -MAG_LO;
      2'b11: w_level =  MAG_LO;
      2'b10: w_level =  MAG_HI;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_lfsr    <= SEED;
      r_mode    <= 2'd0;
      r_imp_cnt <= '0;
      r_x       <= '0;
      r_sym     <= 2'b00;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (sam_clk_en) begin
        if (sym_clk_en) begin
          r_mode  <= mode;
          r_lfsr  <= {r_lfsr[19:0], w_fb1, w_fb2};
          r_sym   <= {w_fb1, w_fb2};
          r_valid <= 1'b1;
        end
        unique case (w_mode_eff)
          2'd0: r_x <= sym_clk_en ? w_level : '0;
          2'd1: if (sym_clk_en) r_x <= w_level;
          2'd2: begin
            // IDLE means we just entered impulse mode: fire immediately and restart the period.
            if (r_state == IDLE || r_imp_cnt == LAST) begin
              r_state   <= PULSE;
              r_imp_cnt <= '0;
              r_x       <= IMP_AMP;
            end else begin
              r_state   <= GAP;
              r_imp_cnt <= r_imp_cnt + CW'(1);
              r_x       <= '0;
            end
          end
          default: r_x <= '0;
        endcase
        if (w_mode_eff != 2'd2) begin
          r_state   <= IDLE;
          r_imp_cnt <= '0;
        end
      end
    end
  end

  assign x_out     = r_x;
  assign sym_out   = r_sym;
  assign sym_valid = r_valid;

endmodule

// File: tb/tb_ask_sym_src.sv
// Randomized self-checking bench for ask_sym_src against a bit-stream level reference model.
module tb_ask_sym_src;

  localparam logic signed [17:0] MAG_HI  = 18'sd98303;
  localparam logic signed [17:0] MAG_LO  = 18'sd32768;
  localparam logic signed [17:0] IMP_AMP = 18'sd98303;
  localparam int unsigned        PER     = 64;

  logic              sys_clk    = 1'b0;
  logic              reset      = 1'b1;
  logic              sam_clk_en = 1'b0;
  logic              sym_clk_en = 1'b0;
  logic [1:0]        mode       = 2'd0;
  logic signed [17:0] x_out;
  logic [1:0]        sym_out;
  logic              sym_valid;

  int n_tests = 0;
  int n_fail  = 0;

  ask_sym_src #(
    .WIDTH(18), .SEED(22'h3FFFFF), .MAG_HI(18'sd98303), .MAG_LO(18'sd32768),
    .IMP_AMP(18'sd98303), .IMP_PERIOD(64)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .mode(mode), .x_out(x_out), .sym_out(sym_out), .sym_valid(sym_valid)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: PRBS as a bit history, s[n] = s[n-22] ^ s[n-21]
  bit                 hist[$];
  int unsigned        phase;
  logic [1:0]         m_mode;
  int unsigned        m_k;
  logic signed [17:0] m_x;
  logic [1:0]         m_sym;
  logic               m_valid;

  task automatic model_reset();
    hist.delete();
    repeat (22) hist.push_back(1'b1);
    phase = 0; m_mode = 2'd0; m_k = 0; m_x = '0; m_sym = 2'b00; m_valid = 1'b0;
  endtask

  function automatic bit next_bit();
    bit b;
    b = hist[0] ^ hist[1];
    void'(hist.pop_front());
    hist.push_back(b);
    return b;
  endfunction

  function automatic logic signed [17:0] level(input logic [1:0] s);
    case (s)
      2'b00:   return -MAG_HI;
      2'b01:   return -MAG_LO;
      2'b11:   return  MAG_LO;
      default: return  MAG_HI;
    endcase
  endfunction

  task automatic model_sample(input bit sym, input logic [1:0] md);
    bit b1, b0;
    m_valid = sym;
    if (sym) begin
      b1 = next_bit();
      b0 = next_bit();
      m_sym = {b1, b0};
      if (md == 2'd2 && m_mode != 2'd2) m_k = 0;
      else m_k++;
      m_mode = md;
    end else begin
      m_k++;
    end
    case (m_mode)
      2'd0:    m_x = sym ? level(m_sym) : 18'sd0;
      2'd1:    if (sym) m_x = level(m_sym);
      2'd2:    m_x = (m_k % PER == 0) ? IMP_AMP : 18'sd0;
      default: m_x = '0;
    endcase
  endtask

  // One sam_clk_en cycle; sym_clk_en coincides on every 4th.
  task automatic step(input logic [1:0] md);
    bit sym;
    sym = (phase == 0);
    @(negedge sys_clk);
    sam_clk_en = 1'b1; sym_clk_en = sym; mode = md;
    @(posedge sys_clk); #1;
    model_sample(sym, md);
    phase = (phase + 1) % 4;
  endtask

  // Cycles without sam_clk_en; sym_clk_en may toggle randomly and must be ignored.
  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge sys_clk);
      sam_clk_en = 1'b0; sym_clk_en = 1'($urandom_range(0, 1));
      @(posedge sys_clk); #1;
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk); reset = 1'b1; sam_clk_en = 1'b0; sym_clk_en = 1'b0;
    @(negedge sys_clk); reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    n_tests++;
    if ({x_out, sym_out, sym_valid} !== {18'sd0, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: x=%0d sym=%b valid=%b, required 0/00/0", x_out, sym_out, sym_valid);
    end
    @(negedge sys_clk); reset = 1'b0;
    model_reset();
  endtask

  task automatic test_mode0();
    logic signed [17:0] exp_x;
    for (int unsigned s = 1; s <= 11; s++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        step(2'd0);
        n_tests++;
        if ({x_out, sym_out, sym_valid} !== {m_x, m_sym, m_valid}) begin
          n_fail++;
          $display("FAIL mode0_model sym %0d smp %0d: got x=%0d sym=%b v=%b, required x=%0d sym=%b v=%b",
                   s, j, x_out, sym_out, sym_valid, m_x, m_sym, m_valid);
        end
        exp_x = (j != 0) ? 18'sd0 : (s <= 10) ? -18'sd98303 : -18'sd32768;
        n_tests++;
        if (x_out !== exp_x) begin
          n_fail++;
          $display("FAIL mode0_seed_seq sym %0d smp %0d: got %0d, required %0d", s, j, x_out, exp_x);
        end
      end
    end
    n_tests++;
    if (sym_out !== 2'b01) begin
      n_fail++;
      $display("FAIL mode0_sym11: got %b, required 01", sym_out);
    end
  endtask

  task automatic test_mode1();
    do_reset();
    for (int unsigned i = 0; i < 44; i++) begin
      step(2'd1);
      n_tests++;
      if ({x_out, sym_out, sym_valid} !== {m_x, m_sym, m_valid} || x_out == 18'sd0) begin
        n_fail++;
        $display("FAIL mode1_hold smp %0d: got x=%0d sym=%b v=%b, required x=%0d sym=%b v=%b",
                 i, x_out, sym_out, sym_valid, m_x, m_sym, m_valid);
      end
    end
  endtask

  task automatic test_impulse();
    int unsigned pulses;
    logic signed [17:0] exp_x;
    pulses = 0;
    for (int unsigned i = 0; i < 200; i++) begin
      step(2'd2);
      exp_x = (i % PER == 0) ? IMP_AMP : 18'sd0;
      if (x_out === IMP_AMP) pulses++;
      n_tests++;
      if (x_out !== exp_x || {sym_out, sym_valid} !== {m_sym, m_valid}) begin
        n_fail++;
        $display("FAIL impulse smp %0d: got x=%0d sym=%b v=%b, required x=%0d sym=%b v=%b",
                 i, x_out, sym_out, sym_valid, exp_x, m_sym, m_valid);
      end
    end
    n_tests++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL impulse_count: got %0d pulses, required 4", pulses);
    end
    while (phase != 0) step(2'd2);
  endtask

  task automatic test_mode_change();
    for (int unsigned i = 0; i < 16; i++) begin
      step((i >= 2) ? 2'd1 : 2'd0);
      n_tests++;
      if ({x_out, sym_out, sym_valid} !== {m_x, m_sym, m_valid}) begin
        n_fail++;
        $display("FAIL mode_change smp %0d: got x=%0d sym=%b v=%b, required x=%0d sym=%b v=%b",
                 i, x_out, sym_out, sym_valid, m_x, m_sym, m_valid);
      end
      if (i == 2 || i == 3) begin
        n_tests++;
        if (x_out !== 18'sd0) begin
          n_fail++;
          $display("FAIL mode_change_deferred smp %0d: got %0d, required 0", i, x_out);
        end
      end
    end
  endtask

  task automatic test_sym_no_sam();
    for (int unsigned k = 0; k < 3; k++) begin
      step(2'd1);
      @(negedge sys_clk); sam_clk_en = 1'b0; sym_clk_en = 1'b1;
      @(posedge sys_clk); #1;
      m_valid = 1'b0;
      n_tests++;
      if ({x_out, sym_out, sym_valid} !== {m_x, m_sym, 1'b0}) begin
        n_fail++;
        $display("FAIL lone_sym_en %0d: got x=%0d sym=%b v=%b, required x=%0d sym=%b v=0",
                 k, x_out, sym_out, sym_valid, m_x, m_sym);
      end
    end
    while (phase != 0) step(2'd1);
    for (int unsigned i = 0; i < 8; i++) begin
      step(2'd0);
      n_tests++;
      if ({x_out, sym_out, sym_valid} !== {m_x, m_sym, m_valid}) begin
        n_fail++;
        $display("FAIL lone_sym_after smp %0d: got x=%0d sym=%b, required x=%0d sym=%b",
                 i, x_out, sym_out, m_x, m_sym);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  md;
    int unsigned gap;
    md = 2'd0;
    for (int unsigned i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) md = 2'($urandom_range(0, 3));
      step(md);
      n_tests++;
      if ({x_out, sym_out, sym_valid} !== {m_x, m_sym, m_valid}) begin
        n_fail++;
        $display("FAIL random smp %0d mode %0d: got x=%0d sym=%b v=%b, required x=%0d sym=%b v=%b",
                 i, md, x_out, sym_out, sym_valid, m_x, m_sym, m_valid);
      end
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        idle(gap);
        n_tests++;
        if ({x_out, sym_out, sym_valid} !== {m_x, m_sym, 1'b0}) begin
          n_fail++;
          $display("FAIL random_idle smp %0d: got x=%0d sym=%b v=%b, required x=%0d sym=%b v=0",
                   i, x_out, sym_out, sym_valid, m_x, m_sym);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int unsigned i = 0; i < 6; i++) step(2'd1);
    @(posedge sys_clk); #3;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({x_out, sym_out, sym_valid} !== {18'sd0, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: x=%0d sym=%b valid=%b, required 0/00/0", x_out, sym_out, sym_valid);
    end
    @(negedge sys_clk); reset = 1'b0; sam_clk_en = 1'b0; sym_clk_en = 1'b0;
    model_reset();
    for (int unsigned i = 0; i < 8; i++) begin
      step(2'd0);
      n_tests++;
      if ({x_out, sym_out, sym_valid} !== {m_x, m_sym, m_valid} ||
          (i == 0 && x_out !== -18'sd98303)) begin
        n_fail++;
        $display("FAIL reset_restart smp %0d: got x=%0d sym=%b v=%b, required x=%0d sym=%b v=%b",
                 i, x_out, sym_out, sym_valid, m_x, m_sym, m_valid);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mode0();
    test_mode1();
    test_impulse();
    test_mode_change();
    test_sym_no_sam();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
